// File: rtl/ketchup_sha3_fifo_axi_if.sv
// AXI4-Lite bus bundle between the PS interconnect and the SHA-3 front end.
interface ketchup_sha3_fifo_axi_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid, awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid, wready;
    logic [1:0]          bresp;
    logic                bvalid, bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid, arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid, rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ketchup_sha3_fifo_axi.sv
// AXI4-Lite front end for the keccak core: buffered message FIFO, absorb/squeeze
// sequencing, latched digest, sticky error flags and a level interrupt.
module ketchup_sha3_fifo_axi #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int C_FIFO_DEPTH       = 16
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESET,
    ketchup_sha3_fifo_axi_if.slave s_axi,
    output logic                   core_reset,
    output logic [31:0]            core_in,
    output logic                   core_in_ready,
    output logic                   core_is_last,
    output logic [1:0]             core_byte_num,
    output logic [1:0]             core_out_size,
    input  logic                   core_buffer_full,
    input  logic [511:0]           core_out,
    input  logic                   core_out_ready,
    output logic                   irq
);
    localparam int PW = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {RST = 2'd0, ABSORB = 2'd1, SQUEEZE = 2'd2, DONE = 2'd3} state_e;
    typedef struct packed {
        logic [31:0] word;
        logic        last;
        logic [1:0]  bnum;
    } entry_t;

    state_e                        state_q;
    logic                          rcnt_q;
    logic                          awready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]                    bresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                    bnum_q, osize_q;
    logic                          irqen_q;
    logic [511:0]                  digest_q;
    logic                          dv_q, ovf_q, seq_q, irq_q;
    logic                          core_reset_q, cir_q, last_q;
    logic [31:0]                   cin_q;
    logic [1:0]                    cbn_q;
    entry_t                        mem_q [C_FIFO_DEPTH];
    logic [PW-1:0]                 wr_q, rd_q;
    logic [CW-1:0]                 cnt_q, cnt_d;

    logic [4:0]  aw_idx, ar_idx, dsel;
    logic        wr_hs, rd_hs, push_req, push_ok, pop, start, ack, ctrl_we, full, empty;
    entry_t      push_e, head;
    logic [31:0] ctrl, status;

    assign aw_idx   = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx   = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign dsel     = ar_idx - 5'd5;
    assign wr_hs    = s_axi.awvalid && s_axi.wvalid && awready_q;
    assign rd_hs    = s_axi.arvalid && arready_q;
    assign full     = (cnt_q == CW'(C_FIFO_DEPTH));
    assign empty    = (cnt_q == '0);
    assign push_req = wr_hs && (aw_idx == 5'd2 || aw_idx == 5'd3);
    assign push_ok  = push_req && (state_q == ABSORB) && !full;
    assign start    = wr_hs && (aw_idx == 5'd4) && s_axi.wdata[0];
    assign ack      = wr_hs && (aw_idx == 5'd4) && s_axi.wdata[1];
    assign ctrl_we  = wr_hs && (aw_idx == 5'd0);
    assign push_e   = {s_axi.wdata[31:0], aw_idx == 5'd3, (aw_idx == 5'd3) ? bnum_q : 2'b00};
    // An empty FIFO forwards the word being pushed so it reaches the core a cycle earlier.
    assign head     = empty ? push_e : mem_q[rd_q];
    assign pop      = (state_q == ABSORB) && (!empty || push_ok) && !core_buffer_full && !cir_q && !start;
    assign cnt_d    = cnt_q + CW'(push_ok) - CW'(pop);

    assign ctrl   = {23'd0, irqen_q, 2'b00, osize_q, 2'b00, bnum_q};
    assign status = {13'd0, 1'b0, state_q, 8'(cnt_q), 2'b00, seq_q, ovf_q,
                     core_buffer_full, empty, full, dv_q};

    always_comb begin
        rdata_d = '0;
        if (ar_idx == 5'd0)                         rdata_d = ctrl;
        else if (ar_idx == 5'd1)                    rdata_d = status;
        else if (ar_idx >= 5'd5 && ar_idx <= 5'd20) rdata_d = digest_q[{~dsel[3:0], 5'b0} +: 32];
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (push_ok) mem_q[wr_q] <= push_e;
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            bnum_q    <= 2'b00;
            osize_q   <= 2'b00;
            irqen_q   <= 1'b0;
        end else begin
            awready_q <= !awready_q && !bvalid_q && s_axi.awvalid && s_axi.wvalid;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (push_req && !push_ok) ? 2'b10 : 2'b00;
            end else if (s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
            arready_q <= !arready_q && !rvalid_q && s_axi.arvalid;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
            end else if (s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
            if (ctrl_we && s_axi.wstrb[0]) begin
                bnum_q  <= s_axi.wdata[1:0];
                osize_q <= s_axi.wdata[5:4];
            end
            if (ctrl_we && s_axi.wstrb[1]) irqen_q <= s_axi.wdata[8];
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q      <= RST;
            rcnt_q       <= 1'b0;
            core_reset_q <= 1'b1;
            cir_q        <= 1'b0;
            last_q       <= 1'b0;
            cin_q        <= '0;
            cbn_q        <= 2'b00;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            digest_q     <= '0;
            dv_q         <= 1'b0;
            ovf_q        <= 1'b0;
            seq_q        <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            cir_q  <= pop;
            last_q <= pop && head.last;
            if (pop) begin
                cin_q <= head.word;
                cbn_q <= head.bnum;
            end
            if (push_ok) wr_q <= wr_q + PW'(1);
            if (pop)     rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_d;
            if (push_req && !push_ok) begin
                if (state_q == ABSORB) ovf_q <= 1'b1;
                else                   seq_q <= 1'b1;
            end
            if (ack) begin
                irq_q <= 1'b0;
                ovf_q <= 1'b0;
                seq_q <= 1'b0;
            end
            case (state_q)
                RST: begin
                    if (rcnt_q) begin
                        state_q      <= ABSORB;
                        core_reset_q <= 1'b0;
                    end else begin
                        rcnt_q <= 1'b1;
                    end
                end
                ABSORB:  if (pop && head.last) state_q <= SQUEEZE;
                SQUEEZE: begin
                    if (core_out_ready) begin
                        digest_q <= core_out;
                        dv_q     <= 1'b1;
                        irq_q    <= irqen_q;
                        state_q  <= DONE;
                    end
                end
                default: ;
            endcase
            // START overrides any pop, latch or flag update in the same cycle.
            if (start) begin
                state_q      <= RST;
                rcnt_q       <= 1'b0;
                core_reset_q <= 1'b1;
                wr_q         <= '0;
                rd_q         <= '0;
                cnt_q        <= '0;
                digest_q     <= '0;
                dv_q         <= 1'b0;
                ovf_q        <= 1'b0;
                seq_q        <= 1'b0;
                irq_q        <= 1'b0;
            end
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = awready_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;
    assign s_axi.rvalid  = rvalid_q;

    assign core_reset    = core_reset_q;
    assign core_in       = cin_q;
    assign core_in_ready = cir_q;
    assign core_is_last  = last_q;
    assign core_byte_num = cbn_q;
    assign core_out_size = osize_q;
    assign irq           = irq_q;

    logic unused_ok;
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0],
                         s_axi.wstrb[3:2], dsel[4]};
endmodule

// File: tb/tb_ketchup_sha3_fifo_axi.sv
// Directed bench for the SHA-3 AXI front end: register table plus FIFO/FSM sequences.
module tb_ketchup_sha3_fifo_axi;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         core_reset, core_in_ready, core_is_last, irq;
    logic [31:0]  core_in;
    logic [1:0]   core_byte_num, core_out_size;
    logic         core_buffer_full = 1'b0;
    logic [511:0] core_out = '0;
    logic         core_out_ready = 1'b0;

    always #5 clk = ~clk;

    ketchup_sha3_fifo_axi_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    ketchup_sha3_fifo_axi #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(7), .C_FIFO_DEPTH(16)) dut (
        .S_AXI_ACLK      (clk),
        .S_AXI_ARESET    (rst),
        .s_axi           (bus),
        .core_reset      (core_reset),
        .core_in         (core_in),
        .core_in_ready   (core_in_ready),
        .core_is_last    (core_is_last),
        .core_byte_num   (core_byte_num),
        .core_out_size   (core_out_size),
        .core_buffer_full(core_buffer_full),
        .core_out        (core_out),
        .core_out_ready  (core_out_ready),
        .irq             (irq)
    );

    typedef struct {
        bit          rd;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  eresp;
        logic [31:0] erdata;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic        last;
        logic [1:0]  bn;
    } strobe_t;

    int        checks = 0;
    int        errors = 0;
    strobe_t   sq[$];
    logic      prev_ir = 1'b0;
    logic      snap_ir, snap_last, snap_rst;
    logic [31:0] snap_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Strobe log; also flags back-to-back strobes and strobes while the core is held in reset.
    always @(negedge clk) begin
        if (core_in_ready) begin
            sq.push_back('{w: core_in, last: core_is_last, bn: core_byte_num});
            checks++;
            if (prev_ir || core_reset) begin
                errors++;
                $display("FAIL strobe_rule: prev=%b core_reset=%b required 0 0", prev_ir, core_reset);
            end
        end
        prev_ir <= core_in_ready;
    end

    task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        n = 0;
        @(negedge clk);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.awready && n < 20);
        if (!bus.awready) begin
            checks++; errors++;
            $display("FAIL write_timeout: addr %h got no awready, required awready within 20 cycles", a);
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            resp = 2'bxx;
            return;
        end
        @(negedge clk);
        snap_ir = core_in_ready; snap_in = core_in; snap_last = core_is_last; snap_rst = core_reset;
        resp = bus.bresp;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("bvalid", 32'(bus.bvalid), 32'd1);
    endtask

    task automatic axi_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        n = 0;
        @(negedge clk);
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.arready && n < 20);
        if (!bus.arready) begin
            checks++; errors++;
            $display("FAIL read_timeout: addr %h got no arready, required arready within 20 cycles", a);
            bus.arvalid = 1'b0;
            d = 'x; r = 'x;
            return;
        end
        @(negedge clk);
        d = bus.rdata; r = bus.rresp;
        bus.arvalid = 1'b0;
        chk("rvalid", 32'(bus.rvalid), 32'd1);
    endtask

    task automatic rd_chk(input string nm, input logic [6:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        chk(nm, d, exp);
    endtask

    task automatic wr_chk(input string nm, input logic [6:0] a, input logic [31:0] d, input logic [1:0] exp);
        logic [1:0] r;
        axi_write(a, d, 4'hF, r);
        chk(nm, 32'(r), 32'(exp));
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int c;
        c = 0;
        while (sq.size() < n && c < budget) begin @(negedge clk); c++; end
    endtask

    task automatic check_rst_window(input string nm);
        chk({nm, "_rst0"}, 32'(snap_rst), 32'd1);
        chk({nm, "_ir0"}, 32'(snap_ir), 32'd0);
        @(negedge clk); chk({nm, "_rst1"}, 32'(core_reset), 32'd1);
        @(negedge clk); chk({nm, "_rst2"}, 32'(core_reset), 32'd0);
    endtask

    initial begin
        vec_t        vt [15];
        logic [1:0]  r;
        logic [31:0] d;
        logic [511:0] dg;
        int          n;
        logic        seen_bv;

        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arprot = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;

        vt[0]  = '{1'b1, 7'h04, 32'h0,        4'h0, 2'b00, 32'h0001_0004};
        vt[1]  = '{1'b0, 7'h00, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
        vt[2]  = '{1'b1, 7'h00, 32'h0,        4'h0, 2'b00, 32'h0000_0133};
        vt[3]  = '{1'b0, 7'h00, 32'h0,        4'h1, 2'b00, 32'h0};
        vt[4]  = '{1'b1, 7'h00, 32'h0,        4'h0, 2'b00, 32'h0000_0100};
        vt[5]  = '{1'b0, 7'h00, 32'h0,        4'h2, 2'b00, 32'h0};
        vt[6]  = '{1'b1, 7'h00, 32'h0,        4'h0, 2'b00, 32'h0};
        vt[7]  = '{1'b1, 7'h08, 32'h0,        4'h0, 2'b00, 32'h0};
        vt[8]  = '{1'b1, 7'h0C, 32'h0,        4'h0, 2'b00, 32'h0};
        vt[9]  = '{1'b1, 7'h10, 32'h0,        4'h0, 2'b00, 32'h0};
        vt[10] = '{1'b1, 7'h7C, 32'h0,        4'h0, 2'b00, 32'h0};
        vt[11] = '{1'b1, 7'h14, 32'h0,        4'h0, 2'b00, 32'h0};
        vt[12] = '{1'b1, 7'h50, 32'h0,        4'h0, 2'b00, 32'h0};
        vt[13] = '{1'b0, 7'h7C, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
        vt[14] = '{1'b1, 7'h04, 32'h0,        4'h0, 2'b00, 32'h0001_0004};

        // Reset state and the two-cycle RST window after release.
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_arready_rvalid", 32'({bus.arready, bus.rvalid}), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_core_in", core_in, 32'd0);
        chk("rst_strobe", 32'({core_in_ready, core_is_last, core_byte_num, core_out_size}), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); chk("rstwin_c0", 32'(core_reset), 32'd1);
        @(negedge clk); chk("rstwin_c1", 32'(core_reset), 32'd1);
        @(negedge clk); chk("rstwin_c2", 32'(core_reset), 32'd0);

        for (int i = 0; i < 15; i++) begin
            if (vt[i].rd) begin
                axi_read(vt[i].addr, d, r);
                chk($sformatf("vec%0d_rdata", i), d, vt[i].erdata);
            end else begin
                axi_write(vt[i].addr, vt[i].data, vt[i].strb, r);
            end
            chk($sformatf("vec%0d_resp", i), 32'(r), 32'(vt[i].eresp));
        end

        // First push lands on the core the cycle after the handshake.
        sq.delete();
        axi_write(7'h08, 32'h1122_3344, 4'hF, r);
        chk("b_resp", 32'(r), 32'd0);
        chk("b_ir", 32'(snap_ir), 32'd1);
        chk("b_in", snap_in, 32'h1122_3344);
        chk("b_last", 32'(snap_last), 32'd0);
        @(negedge clk); chk("b_ir_pulse", 32'(core_in_ready), 32'd0);

        // Three data words then a last word with byte_num from CONTROL.
        wr_chk("c_ctrl", 7'h00, 32'h12, 2'b00);
        chk("c_out_size", 32'(core_out_size), 32'd1);
        sq.delete();
        for (int i = 0; i < 3; i++) wr_chk("c_push", 7'h08, 32'hC000_0000 + i, 2'b00);
        wr_chk("c_push_last", 7'h0C, 32'hC000_00FF, 2'b00);
        wait_strobes(4, 20);
        chk("c_count", sq.size(), 4);
        if (sq.size() == 4) begin
            for (int i = 0; i < 3; i++) begin
                chk("c_word", sq[i].w, 32'hC000_0000 + i);
                chk("c_notlast", 32'(sq[i].last), 32'd0);
            end
            chk("c_lword", sq[3].w, 32'hC000_00FF);
            chk("c_islast", 32'(sq[3].last), 32'd1);
            chk("c_bnum", 32'(sq[3].bn), 32'd2);
        end
        rd_chk("c_status", 7'h04, 32'h0002_0004);

        // Overflow with the core stalled, then an in-order drain with a mid-drain stall.
        wr_chk("d_start", 7'h10, 32'h1, 2'b00);
        repeat (3) @(negedge clk);
        core_buffer_full = 1'b1;
        sq.delete();
        for (int i = 0; i < 17; i++)
            wr_chk($sformatf("d_push%0d", i), 7'h08, 32'hA000_0000 + i, (i == 16) ? 2'b10 : 2'b00);
        rd_chk("d_status", 7'h04, 32'h0001_101A);
        chk("d_no_strobe", sq.size(), 0);
        @(negedge clk); core_buffer_full = 1'b0;
        n = 0;
        while (!core_in_ready && n < 10) begin @(negedge clk); n++; end
        chk("d_first_strobe", 32'(core_in_ready), 32'd1);
        core_buffer_full = 1'b1;
        repeat (6) @(negedge clk);
        chk("d_stall", sq.size(), 1);
        core_buffer_full = 1'b0;
        wait_strobes(16, 80);
        chk("d_count", sq.size(), 16);
        if (sq.size() == 16)
            for (int i = 0; i < 16; i++) chk($sformatf("d_word%0d", i), sq[i].w, 32'hA000_0000 + i);
        rd_chk("d_level0", 7'h04, 32'h0001_0014);

        // Digest latch, interrupt, ACK and a push while DONE.
        wr_chk("e_start", 7'h10, 32'h1, 2'b00);
        repeat (3) @(negedge clk);
        axi_write(7'h00, 32'h100, 4'h3, r);
        axi_write(7'h0C, 32'hDEAD_BEEF, 4'hF, r);
        chk("e_last_strobe", 32'({snap_ir, snap_last}), 32'd3);
        rd_chk("e_squeeze", 7'h04, 32'h0002_0004);
        for (int i = 0; i < 64; i++) dg[511 - 8*i -: 8] = 8'(i + 1);
        core_out = dg;
        core_out_ready = 1'b1;
        chk("e_irq_before", 32'(irq), 32'd0);
        @(negedge clk);
        core_out_ready = 1'b0;
        chk("e_irq", 32'(irq), 32'd1);
        rd_chk("e_dig0", 7'h14, 32'h0102_0304);
        rd_chk("e_dig15", 7'h50, 32'h3D3E_3F40);
        rd_chk("e_status", 7'h04, 32'h0003_0005);
        wr_chk("e_ack", 7'h10, 32'h2, 2'b00);
        chk("e_irq_ack", 32'(irq), 32'd0);
        wr_chk("e_push_done", 7'h08, 32'h5555_5555, 2'b10);
        rd_chk("e_seq", 7'h04, 32'h0003_0025);

        // START mid-absorb with five queued words.
        wr_chk("f_start0", 7'h10, 32'h1, 2'b00);
        repeat (3) @(negedge clk);
        rd_chk("f_cleared", 7'h04, 32'h0001_0004);
        rd_chk("f_dig0", 7'h14, 32'h0);
        core_buffer_full = 1'b1;
        for (int i = 0; i < 5; i++) wr_chk("f_push", 7'h08, 32'hF000_0000 + i, 2'b00);
        rd_chk("f_level5", 7'h04, 32'h0001_0508);
        sq.delete();
        axi_write(7'h10, 32'h1, 4'hF, r);
        core_buffer_full = 1'b0;
        check_rst_window("f");
        repeat (10) @(negedge clk);
        chk("f_no_strobe", sq.size(), 0);
        rd_chk("f_flushed", 7'h04, 32'h0001_0004);

        // Asynchronous reset in the middle of a write.
        wr_chk("g_ctrl", 7'h00, 32'h12, 2'b00);
        @(negedge clk);
        bus.awaddr = 7'h08; bus.wdata = 32'h7777_7777; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.awready && n < 20);
        chk("g_awready_seen", 32'(bus.awready), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("g_awready", 32'({bus.awready, bus.wready, bus.bvalid}), 32'd0);
        chk("g_core_reset", 32'(core_reset), 32'd1);
        chk("g_outs", 32'({core_in_ready, core_out_size, irq}), 32'd0);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        seen_bv = 1'b0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); seen_bv |= bus.bvalid; end
        chk("g_no_bvalid", 32'(seen_bv), 32'd0);
        rd_chk("g_ctrl0", 7'h00, 32'h0);
        rd_chk("g_status", 7'h04, 32'h0001_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required completion before 400us");
        $fatal(1);
    end
endmodule
